cn_msg_gen: RTL
===============

Name: cn_msg_gen

Overview:
- Check-node output stage of the min-sum LDPC decoder. Sits directly downstream of the 8-input min1/min2/index finder.
- Takes the finder's min1, min2 and 3-bit position of min1, plus the 8 input signs (delay-matched upstream). Applies offset-min-sum correction.
- Emits the 8 check-to-variable messages serially, one per beat, as W-bit two's complement, under a valid/ready handshake.

Parameters:
- W, 6, full message width in bits; magnitudes are W-1 bits.
- Wc, 8, check-node degree. Fixed at 8, so the index is 3 bits.
- OFFSET, 1, offset subtracted from min1/min2 with saturation at 0. Range 0..2^(W-1)-1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- in_valid  input  1  min1/min2/q2q1q0/sgn valid this cycle
- in_ready  output  1  block can accept a new check-node result
- min1  input  W-1  smallest input magnitude
- min2  input  W-1  second-smallest input magnitude
- q2q1q0  input  3  position (0..7) of min1
- sgn  input  Wc  sign bits of the 8 inputs, bit i = input i (1 = negative)
- out_valid  output  1  out_msg/out_idx/out_last valid
- out_ready  input  1  downstream accepts the current beat
- out_msg  output  W  two's-complement message for edge out_idx
- out_idx  output  3  edge index of current beat, 0..7
- out_last  output  1  high on the beat with out_idx==7

Behaviour:
- Reset, when rst==0 at a clk edge:
  - state=IDLE, out_valid=0, out_idx=0.
  - All held registers = 0, so out_msg=0 and out_last=0.
  - Reset applied mid-emission abandons the current node with no further beats.
- FSM states: IDLE, EMIT.
- in_ready is combinational: high when state==IDLE, or when state==EMIT && out_valid && out_ready && out_last.
- Accept occurs when in_valid && in_ready. On accept, register:
  - m1o = sat0(min1-OFFSET)
  - m2o = sat0(min2-OFFSET)
  - q = q2q1q0
  - s = sgn
  - par = XOR of all 8 sgn bits
- Latency: accept at edge T gives out_valid=1 with out_idx=0 from T+1. One node takes at least 8 beats. Peak throughput is one node per 8 cycles, with no bubble between nodes.
- Beat contents, combinational from held registers:
  - mag = (out_idx==q) ? m2o : m1o
  - neg = par ^ s[out_idx]
  - out_msg = neg ? -mag : mag, in W bits. A zero magnitude gives 0 regardless of sign. Range is ±(2^(W-1)-1); no overflow is possible.
- Handshake:
  - A beat transfers when out_valid && out_ready, and out_idx then increments.
  - While out_valid && !out_ready, out_msg, out_idx and out_last hold stable.
  - out_valid never drops before the beat with out_idx==7 transfers.
- Last beat:
  - If a new accept occurs in the same cycle, stay in EMIT, set out_idx=0 and use the new data.
  - Otherwise go to IDLE with out_valid=0.
- in_valid while busy (in_ready low) is ignored. The upstream must hold its data.
- No check that min2>=min1; the values are used as given. OFFSET=0 passes magnitudes unchanged.

Test Plan:
- W=6, OFFSET=1; min1=3, min2=7, q=5, sgn=8'h00 -> beats idx0..7 = 2,2,2,2,2,6,2,2. out_last only at idx7. in_ready low from the accept cycle until the last beat.
- Same magnitudes, sgn=8'h01 (par=1):
  - idx0 = +2
  - idx5 = -6 = 6'b111010
  - all other indices = -2 = 6'b111110
- min1=0, min2=1, q=2, sgn=8'hFF -> all 8 beats out_msg=0. Covers saturation and zero with negative sign.
- min1=31, min2=31, q=0, sgn=8'h03 (par=0):
  - idx0 and idx1 = -30 = 6'b100010
  - all other indices = +30 = 6'b011110
- Backpressure:
  - out_ready=0 for 3 cycles at idx3 -> out_msg and out_idx=3 hold, out_valid stays 1. Beat order is unchanged after release.
  - Second node presented with in_valid during the last beat -> accepted that cycle; next cycle idx0 carries the new data (no bubble).
- Reset: rst=0 during idx4 -> next cycle out_valid=0, out_idx=0, in_ready=1, out_msg=0. A fresh accept then restarts at idx0.

Source files
------------

// File: rtl/cn_msg_gen_if.sv
// Check-node result in, serial check-to-variable messages out.
// The slave side is the message generator; the master side is its environment.
interface cn_msg_gen_if #(
    parameter int W  = 6,
    parameter int WC = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [W-2:0]  min1;
    logic [W-2:0]  min2;
    logic [2:0]    q2q1q0;
    logic [WC-1:0] sgn;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_msg;
    logic [2:0]    out_idx;
    logic          out_last;

    modport master (
        output in_valid, min1, min2, q2q1q0, sgn, out_ready,
        input  in_ready, out_valid, out_msg, out_idx, out_last
    );

    modport slave (
        input  in_valid, min1, min2, q2q1q0, sgn, out_ready,
        output in_ready, out_valid, out_msg, out_idx, out_last
    );
endinterface

// File: rtl/cn_msg_gen.sv
// Offset-min-sum check-node output stage: latches one min1/min2/index/sign
// result and streams the 8 check-to-variable messages, one per beat.
module cn_msg_gen #(
    parameter int W      = 6,
    parameter int WC     = 8,
    parameter int OFFSET = 1
) (
    input  logic         clk,
    input  logic         rst,
    cn_msg_gen_if.slave  bus
);
    localparam int MW = W - 1;
    localparam logic [MW-1:0] OFF = MW'(OFFSET);

    typedef enum logic {IDLE, EMIT} state_t;

    typedef struct packed {
        logic [MW-1:0] m1o;
        logic [MW-1:0] m2o;
        logic [2:0]    q;
        logic [WC-1:0] s;
        logic          par;
    } node_t;

    state_t        state;
    node_t         node;
    logic [2:0]    idx;
    logic          beat;
    logic          accept;
    logic [MW-1:0] mag;
    logic          neg;
    logic [W-1:0]  mag_ext;

    function automatic logic [MW-1:0] sat0(input logic [MW-1:0] v);
        return (v >= OFF) ? v - OFF : '0;
    endfunction

    assign bus.out_valid = (state == EMIT);
    assign bus.out_idx   = idx;
    assign bus.out_last  = (state == EMIT) && (idx == 3'd7);

    assign beat         = bus.out_valid && bus.out_ready;
    // A new node may slip in on the final beat so back-to-back nodes have no gap.
    assign bus.in_ready = (state == IDLE) || (beat && bus.out_last);
    assign accept       = bus.in_valid && bus.in_ready;

    // Edge q (the min1 owner) gets min2; sign is the product of all other signs.
    assign mag         = (idx == node.q) ? node.m2o : node.m1o;
    assign neg         = node.par ^ node.s[idx];
    assign mag_ext     = {1'b0, mag};
    assign bus.out_msg = neg ? (~mag_ext + W'(1)) : mag_ext;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            node  <= '0;
            idx   <= '0;
        end else if (accept) begin
            state    <= EMIT;
            idx      <= '0;
            node.m1o <= sat0(bus.min1);
            node.m2o <= sat0(bus.min2);
            node.q   <= bus.q2q1q0;
            node.s   <= bus.sgn;
            node.par <= ^bus.sgn;
        end else if (beat) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7)
                state <= IDLE;
        end
    end
endmodule
